// File: rtl/and_pkg.sv
// ---------------------------------------------------------------------------
// and_pkg
//  Shared types for the 4-bit AND datapath stage and its operand FIFO.
//   AND_W      : operand width of the AND stage
//   operand_t  : one operand
//   and_pair_t : one (a,b) operand pair as stored in the FIFO
// ---------------------------------------------------------------------------
package and_pkg;
    localparam int AND_W = 4;

    typedef logic [AND_W-1:0] operand_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
    } and_pair_t;
endpackage

// File: rtl/and_operand_fifo.sv
// ---------------------------------------------------------------------------
// and_operand_fifo
//  First-word fall-through FIFO of operand pairs (a,b) in front of the 4-bit
//  AND stage. The producer pushes with valid/ready; the head pair drives the
//  AND stage operands, which pops it with i_out_ready.
//
//  Optional feature: define AND_FIFO_STATS_EN to add the statistics ports
//  o_drop_cnt and o_max_count. Without the macro those ports do not exist.
//
//  Ports
//   i_clk         rising-edge clock
//   i_rst         synchronous reset, active-high
//   i_in_valid    upstream pair valid
//   o_in_ready    FIFO can accept a pair this cycle
//   i_in_a/i_in_b operands to store
//   o_out_valid   head pair present
//   i_out_ready   AND stage consumes the head this cycle
//   o_out_a/o_out_b head operands (0 when empty)
//   o_count       occupancy 0..DEPTH
//   o_drop_cnt    (stats) cycles with in_valid & !in_ready, saturating at 255
//   o_max_count   (stats) high-water occupancy
//
//  DATA_W must equal and_pkg::AND_W since entries are stored as and_pair_t.
// ---------------------------------------------------------------------------
module and_operand_fifo
    import and_pkg::*;
#(
    parameter int DATA_W = AND_W,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [DATA_W-1:0]          i_in_a,
    input  logic [DATA_W-1:0]          i_in_b,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_W-1:0]          o_out_a,
    output logic [DATA_W-1:0]          o_out_b,
    output logic [$clog2(DEPTH):0]     o_count
`ifdef AND_FIFO_STATS_EN
    ,
    output logic [7:0]                 o_drop_cnt,
    output logic [$clog2(DEPTH):0]     o_max_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    and_pair_t        r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    and_pair_t        w_head;

    assign w_full      = (r_count == FULL_CNT);
    // Gated by i_rst so nothing is accepted while reset is held.
    assign o_in_ready  = !w_full && !i_rst;
    assign o_out_valid = (r_count != '0);
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr].a <= i_in_a;
            r_mem[r_wr_ptr].b <= i_in_b;
        end
    end

    // Fall-through head, forced to zero when empty so the AND stage sees 0.
    assign w_head  = o_out_valid ? r_mem[r_rd_ptr] : '0;
    assign o_out_a = w_head.a;
    assign o_out_b = w_head.b;
    assign o_count = r_count;

`ifdef AND_FIFO_STATS_EN
    logic [7:0]    r_drop_cnt;
    logic [CW-1:0] r_max_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt  <= '0;
            r_max_count <= '0;
        end else begin
            if (i_in_valid && !o_in_ready && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
            // Track the post-edge occupancy so the peak shows without lag.
            if (w_count_nxt > r_max_count)
                r_max_count <= w_count_nxt;
        end
    end

    assign o_drop_cnt  = r_drop_cnt;
    assign o_max_count = r_max_count;
`endif

endmodule
